instruction_loader: RTL
=======================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter PC_BITS, default 32, meaning the width of the instruction-memory address output.
REQ-002 The block SHALL have parameter INSTRUCTION_BITS, default 32, meaning the instruction word width; it must be a multiple of 8.
REQ-003 The block SHALL have parameter INST_ADDRS_BITS, default 8, meaning the number of implemented instruction-memory address bits.
REQ-004 The block SHALL have parameter HALT_WORD, default all ones, meaning the instruction word that terminates a program load.
REQ-005 The block SHALL use one clock and a synchronous, active-low reset, on ports clk and rst.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous active-low reset.
REQ-008 The block SHALL have port i_rx_data, input, 8 bits: received byte.
REQ-009 The block SHALL have port i_rx_valid, input, 1 bit: one-cycle strobe, i_rx_data valid; the block applies no backpressure.
REQ-010 The block SHALL have port i_halt, input, 1 bit: the pipeline has retired the halt instruction.
REQ-011 The block SHALL have port o_enable, output, 1 bit: pipeline and fetch advance enable.
REQ-012 The block SHALL have port o_write_inst_mem, output, 1 bit: instruction-memory write strobe.
REQ-013 The block SHALL have port o_inst_mem_addr, output, PC_BITS bits: write address, zero-extended from INST_ADDRS_BITS.
REQ-014 The block SHALL have port o_inst_mem_data, output, INSTRUCTION_BITS bits: assembled instruction word.
REQ-015 The block SHALL have port o_done, output, 1 bit: program finished (DONE state).
REQ-016 The block SHALL have port o_load_full, output, 1 bit: sticky flag, the last memory location was written without a HALT_WORD.

Function
REQ-017 The block SHALL implement states IDLE, LOAD, WRITE, READY, RUN, STEP and DONE.
REQ-018 In IDLE, a byte 8'h4C ('L') SHALL clear the address counter, byte counter and o_load_full, then go to LOAD; any other byte SHALL be ignored.
REQ-019 In LOAD, each i_rx_valid byte SHALL shift into the word register MSB-first; when the INSTRUCTION_BITS/8-th byte arrives, the block SHALL go to WRITE on the next cycle.
REQ-020 WRITE SHALL last exactly 1 cycle, with o_write_inst_mem=1, o_inst_mem_addr = current address, and o_inst_mem_data = the assembled word; the address SHALL then increment.
REQ-021 From WRITE, the block SHALL go to READY if the word equals HALT_WORD or the address equals 2^INST_ADDRS_BITS-1; in the full case without HALT_WORD it SHALL set o_load_full. Otherwise it SHALL return to LOAD with the byte counter at 0.
REQ-022 A byte arriving during WRITE SHALL be counted as the first byte of the next word and SHALL NOT be lost.
REQ-023 The address counter SHALL never wrap to 0 during a load; reaching the full condition always ends the load.
REQ-024 In READY, 'C' (8'h43) SHALL go to RUN, 'S' (8'h53) SHALL go to STEP, and 'L' SHALL restart the load as in REQ-018; other bytes and i_halt SHALL be ignored.
REQ-025 In RUN, o_enable SHALL be 1 every cycle; when i_halt=1, o_enable SHALL be 0 from the next cycle and the state SHALL become DONE.
REQ-026 STEP SHALL assert o_enable for exactly 1 cycle, then go to READY, or to DONE if i_halt=1 in that cycle.
REQ-027 In DONE, o_done SHALL be 1 and o_enable 0; an 'R' (8'h52) SHALL go to IDLE, and all other input SHALL be ignored.
REQ-028 o_enable SHALL be 0 in every state except RUN and STEP, and o_write_inst_mem SHALL be 0 except in WRITE; the two outputs SHALL never both be 1.
REQ-029 All outputs SHALL be registered or decoded from state only, with no combinational path from i_rx_* to any output.

Reset
REQ-030 When rst=0 at posedge, the block SHALL enter IDLE, clear the address, byte counter and word register, and set o_enable=0, o_write_inst_mem=0, o_inst_mem_addr=0, o_inst_mem_data=0, o_done=0 and o_load_full=0; this SHALL apply from any state, including mid-word or mid-RUN.
REQ-031 Partial words received before a reset SHALL be discarded.

Verification
REQ-032 A bench SHALL drive 'L', bytes 00 00 00 01, then FF FF FF FF, and check two writes: addr 0 / data 32'h00000001, then addr 1 / data 32'hFFFFFFFF, followed by READY with o_enable=0.
REQ-033 A bench SHALL drive, from READY, 'S' three times and check exactly three single-cycle o_enable pulses with o_done=0.
REQ-034 A bench SHALL drive, from READY, 'C' then i_halt=1 after 10 cycles, and check o_enable high for exactly 10 cycles, then 0, with o_done=1.
REQ-035 A bench SHALL use INST_ADDRS_BITS=2, load 4 non-halt words, and check writes at addresses 0-3, o_load_full=1 and READY with no wrap.
REQ-036 A bench SHALL assert rst=0 after 2 bytes of a word, then release it and send 'L' plus 4 bytes, and check that the first write is at addr 0 and contains only the new bytes.
REQ-037 A bench SHALL send a byte in the cycle the block is in WRITE and check that it becomes the MSB of the next word.

Source files
------------

// File: rtl/instruction_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instruction_loader                                           |
// | Description : Byte-stream program loader for an instruction memory, with   |
// |               run / single-step / done control of the pipeline enable.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// INSTRUCTION_BITS must be a multiple of 8; words are assembled MSB-first.
module instruction_loader #(
  parameter int                          PC_BITS          = 32,
  parameter int                          INSTRUCTION_BITS = 32,
  parameter int                          INST_ADDRS_BITS  = 8,
  parameter logic [INSTRUCTION_BITS-1:0] HALT_WORD        = '1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  i_rx_data,
  input  logic                        i_rx_valid,
  input  logic                        i_halt,
  output logic                        o_enable,
  output logic                        o_write_inst_mem,
  output logic [PC_BITS-1:0]          o_inst_mem_addr,
  output logic [INSTRUCTION_BITS-1:0] o_inst_mem_data,
  output logic                        o_done,
  output logic                        o_load_full
);

  localparam int                         BYTES    = INSTRUCTION_BITS / 8;
  localparam int                         CNT_W    = $clog2(BYTES + 1);
  localparam logic [CNT_W-1:0]           LAST_CNT = CNT_W'(BYTES - 1);
  localparam logic [INST_ADDRS_BITS-1:0] ADDR_MAX = '1;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_CONT  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_RESET = 8'h52;  // 'R'

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_READY = 3'd3,
    S_RUN   = 3'd4,
    S_STEP  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                        state_q, state_d;
  logic [INST_ADDRS_BITS-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [INSTRUCTION_BITS-1:0]   word_q, word_d;
  logic                          full_q, full_d;

  logic [INSTRUCTION_BITS-1:0]   w_word_shift;
  logic                          w_is_halt_word;
  logic                          w_at_max;

  // Word register with the incoming byte appended as the new LSB.
  always_comb begin
    w_word_shift   = (word_q << 8) | INSTRUCTION_BITS'(i_rx_data);
    w_is_halt_word = (word_q == HALT_WORD);
    w_at_max       = (addr_q == ADDR_MAX);
  end

  // Next-state and datapath update for the load / run control FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    full_d  = full_q;

    case (state_q)
      S_IDLE: begin
        if (i_rx_valid && (i_rx_data == CMD_LOAD)) begin
          addr_d  = '0;
          cnt_d   = '0;
          full_d  = 1'b0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (i_rx_valid) begin
          word_d = w_word_shift;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = S_WRITE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_WRITE: begin
        cnt_d = '0;
        if (w_is_halt_word || w_at_max) begin
          // The last location is never followed by an increment, so the
          // address cannot wrap back to zero.
          state_d = S_READY;
          if (!w_at_max) begin
            addr_d = addr_q + INST_ADDRS_BITS'(1);
          end
          if (w_at_max && !w_is_halt_word) begin
            full_d = 1'b1;
          end
        end else begin
          addr_d  = addr_q + INST_ADDRS_BITS'(1);
          state_d = S_LOAD;
          // A byte landing during the write is the first byte of the next word.
          if (i_rx_valid) begin
            word_d = w_word_shift;
            if (LAST_CNT == '0) begin
              state_d = S_WRITE;
            end else begin
              cnt_d = CNT_W'(1);
            end
          end
        end
      end

      S_READY: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_CONT) begin
            state_d = S_RUN;
          end else if (i_rx_data == CMD_STEP) begin
            state_d = S_STEP;
          end else if (i_rx_data == CMD_LOAD) begin
            addr_d  = '0;
            cnt_d   = '0;
            full_d  = 1'b0;
            state_d = S_LOAD;
          end
        end
      end

      S_RUN: begin
        if (i_halt) begin
          state_d = S_DONE;
        end
      end

      S_STEP: begin
        state_d = i_halt ? S_DONE : S_READY;
      end

      S_DONE: begin
        if (i_rx_valid && (i_rx_data == CMD_RESET)) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also discards any partial word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      full_q  <= full_d;
    end
  end

  // Outputs come only from registers or the state decode.
  always_comb begin
    o_enable         = (state_q == S_RUN) || (state_q == S_STEP);
    o_write_inst_mem = (state_q == S_WRITE);
    o_inst_mem_addr  = PC_BITS'(addr_q);
    o_inst_mem_data  = word_q;
    o_done           = (state_q == S_DONE);
    o_load_full      = full_q;
  end

endmodule
`default_nettype wire
